// File: rtl/regfile_2w_sb.sv
// rtl/regfile_2w_sb.sv - RV32 integer register file with WB/LD write ports and load scoreboard
module regfile_2w_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            areset,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_wa,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            ld_we,
  input  logic [AW-1:0]   ld_wa,
  input  logic [XLEN-1:0] ld_wd,
  output logic            busy_any
);

  generate
    if (NREG < 2 || AW != $clog2(NREG) || (1 << AW) != NREG) begin : g_param_chk
      $error("regfile_2w_sb: NREG must be a power of 2 >= 2 and AW must equal log2(NREG)");
    end
  endgenerate

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_sb;
  logic            r_busy_any;
  logic [NREG-1:0] w_sb_next;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic            w_busy1;
  logic            w_busy2;

  // A new issue supersedes a load returning to the same register in the same cycle.
  always_comb begin
    w_sb_next = r_sb;
    for (int i = 0; i < NREG; i++) begin
      if (iss_valid && iss_rd == AW'(i))
        w_sb_next[i] = 1'b1;
      else if (ld_we && ld_wa == AW'(i))
        w_sb_next[i] = 1'b0;
    end
    w_sb_next[0] = 1'b0;
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
    if (!areset || ra == '0)
      return '0;
    else if (BYPASS != 0 && ld_we && ld_wa == ra)
      return ld_wd;
    else if (BYPASS != 0 && wb_we && wb_wa == ra)
      return wb_wd;
    else
      return r_regs[ra];
  endfunction

  // With bypass the returning load data is forwarded, so the register is no longer a hazard.
  function automatic logic busy_port(input logic [AW-1:0] ra);
    return areset && ra != '0 && r_sb[ra] && !(BYPASS != 0 && ld_we && ld_wa == ra);
  endfunction

  always_comb begin
    w_rd1   = read_port(ra1);
    w_rd2   = read_port(ra2);
    w_busy1 = busy_port(ra1);
    w_busy2 = busy_port(ra2);
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
      r_sb       <= '0;
      r_busy_any <= 1'b0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (ld_we && ld_wa == AW'(i))
          r_regs[i] <= ld_wd;
        else if (wb_we && wb_wa == AW'(i))
          r_regs[i] <= wb_wd;
      end
      r_sb       <= w_sb_next;
      r_busy_any <= |r_sb;
    end
  end

  assign rd1      = w_rd1;
  assign rd2      = w_rd2;
  assign busy1    = w_busy1;
  assign busy2    = w_busy2;
  assign busy_any = r_busy_any;

endmodule

// File: tb/tb_regfile_2w_sb.sv
// tb/tb_regfile_2w_sb.sv - directed bench for regfile_2w_sb, bypass and non-bypass instances
module tb_regfile_2w_sb;

  logic        clk = 1'b0;
  logic        areset;
  logic [4:0]  ra1, ra2, iss_rd, wb_wa, ld_wa;
  logic        iss_valid, wb_we, ld_we;
  logic [31:0] wb_wd, ld_wd;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy1_a, busy2_a, busy_any_a, busy1_b, busy2_b, busy_any_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_2w_sb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1)) dut_a (
    .clk(clk), .areset(areset), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .busy1(busy1_a), .busy2(busy2_a), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .ld_we(ld_we), .ld_wa(ld_wa),
    .ld_wd(ld_wd), .busy_any(busy_any_a)
  );

  regfile_2w_sb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(0)) dut_b (
    .clk(clk), .areset(areset), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .busy1(busy1_b), .busy2(busy2_b), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .ld_we(ld_we), .ld_wa(ld_wa),
    .ld_wd(ld_wd), .busy_any(busy_any_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_rd = 0; wb_we = 0; wb_wa = 0; wb_wd = 0;
    ld_we = 0; ld_wa = 0; ld_wd = 0;
  endtask

  task automatic test_reset();
    idle(); ra1 = 0; ra2 = 0;
    areset = 1'b0;
    tick(); tick();
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      checks++;
      if ({rd1_a, rd2_a, rd1_b, rd2_b} !== 128'd0) begin
        failures++;
        $display("FAIL reset_rd addr=%0d got=%h/%h/%h/%h exp=0", i, rd1_a, rd2_a, rd1_b, rd2_b);
      end
      checks++;
      if ({busy1_a, busy2_a, busy1_b, busy2_b, busy_any_a, busy_any_b} !== 6'b0) begin
        failures++;
        $display("FAIL reset_busy addr=%0d got=%b exp=000000", i,
                 {busy1_a, busy2_a, busy1_b, busy2_b, busy_any_a, busy_any_b});
      end
    end
    #2 areset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    wb_we = 1; wb_wa = 5; wb_wd = 32'hDEADBEEF;
    tick();
    idle(); ra1 = 5;
    #1;
    checks++;
    if (rd1_a !== 32'hDEADBEEF || rd1_b !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_x5 got=%h/%h exp=deadbeef", rd1_a, rd1_b);
    end
    wb_we = 1; wb_wa = 0; wb_wd = 32'h1234; ra2 = 0;
    #1;
    checks++;
    if (rd2_a !== 32'h0 || rd2_b !== 32'h0) begin
      failures++;
      $display("FAIL x0_bypass got=%h/%h exp=0", rd2_a, rd2_b);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd2_a !== 32'h0 || rd2_b !== 32'h0) begin
      failures++;
      $display("FAIL x0_stored got=%h/%h exp=0", rd2_a, rd2_b);
    end
  endtask

  task automatic test_bypass();
    ra2 = 7; wb_we = 1; wb_wa = 7; wb_wd = 32'hA5A5A5A5;
    #1;
    checks++;
    if (rd2_a !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL bypass_fwd got=%h exp=a5a5a5a5", rd2_a);
    end
    checks++;
    if (rd2_b !== 32'h0) begin
      failures++;
      $display("FAIL nobypass_old got=%h exp=0", rd2_b);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd2_b !== 32'hA5A5A5A5 || rd2_a !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL bypass_next got=%h/%h exp=a5a5a5a5", rd2_a, rd2_b);
    end
  endtask

  task automatic test_conflict();
    ra1 = 9;
    wb_we = 1; wb_wa = 9; wb_wd = 32'h11111111;
    ld_we = 1; ld_wa = 9; ld_wd = 32'h22222222;
    #1;
    checks++;
    if (rd1_a !== 32'h22222222) begin
      failures++;
      $display("FAIL conflict_fwd got=%h exp=22222222", rd1_a);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd1_a !== 32'h22222222 || rd1_b !== 32'h22222222) begin
      failures++;
      $display("FAIL conflict_stored got=%h/%h exp=22222222", rd1_a, rd1_b);
    end
    wb_we = 1; wb_wa = 3; wb_wd = 32'h1;
    ld_we = 1; ld_wa = 4; ld_wd = 32'h2;
    tick();
    idle(); ra1 = 3; ra2 = 4;
    #1;
    checks++;
    if (rd1_a !== 32'h1 || rd1_b !== 32'h1 || rd2_a !== 32'h2 || rd2_b !== 32'h2) begin
      failures++;
      $display("FAIL dual_write got=%h/%h %h/%h exp=1 2", rd1_a, rd1_b, rd2_a, rd2_b);
    end
  endtask

  task automatic test_scoreboard();
    ra1 = 10; ra2 = 0;
    iss_valid = 1; iss_rd = 10;
    #1;
    checks++;
    if (busy1_a !== 1'b0 || busy1_b !== 1'b0) begin
      failures++;
      $display("FAIL issue_same_cycle got=%b/%b exp=0", busy1_a, busy1_b);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy1_a !== 1'b1 || busy1_b !== 1'b1) begin
      failures++;
      $display("FAIL issue_busy got=%b/%b exp=1", busy1_a, busy1_b);
    end
    tick();
    checks++;
    if (busy_any_a !== 1'b1 || busy_any_b !== 1'b1) begin
      failures++;
      $display("FAIL busy_any_set got=%b/%b exp=1", busy_any_a, busy_any_b);
    end
    ld_we = 1; ld_wa = 10; ld_wd = 32'h55;
    #1;
    checks++;
    if (busy1_a !== 1'b0 || rd1_a !== 32'h55) begin
      failures++;
      $display("FAIL ld_fwd busy=%b rd=%h exp busy=0 rd=55", busy1_a, rd1_a);
    end
    checks++;
    if (busy1_b !== 1'b1 || rd1_b !== 32'h0) begin
      failures++;
      $display("FAIL ld_nofwd busy=%b rd=%h exp busy=1 rd=0", busy1_b, rd1_b);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy1_a !== 1'b0 || busy1_b !== 1'b0 || rd1_b !== 32'h55) begin
      failures++;
      $display("FAIL ld_clear busy=%b/%b rd=%h exp 0/0 55", busy1_a, busy1_b, rd1_b);
    end
    iss_valid = 1; iss_rd = 10;
    tick();
    iss_valid = 1; iss_rd = 10; ld_we = 1; ld_wa = 10; ld_wd = 32'h66;
    tick();
    idle();
    #1;
    checks++;
    if (busy1_a !== 1'b1 || busy1_b !== 1'b1 || rd1_a !== 32'h66) begin
      failures++;
      $display("FAIL set_wins busy=%b/%b rd=%h exp 1/1 66", busy1_a, busy1_b, rd1_a);
    end
    iss_valid = 1; iss_rd = 0; wb_we = 1; wb_wa = 10; wb_wd = 32'h77;
    tick();
    idle();
    #1;
    checks++;
    if (busy2_a !== 1'b0 || busy2_b !== 1'b0 || busy1_a !== 1'b1) begin
      failures++;
      $display("FAIL x0_issue_wb busy2=%b/%b busy1=%b exp 0/0 1", busy2_a, busy2_b, busy1_a);
    end
    ld_we = 1; ld_wa = 10; ld_wd = 32'h88;
    tick();
    idle();
    tick(); tick();
    checks++;
    if (busy_any_a !== 1'b0 || busy_any_b !== 1'b0 || busy1_a !== 1'b0) begin
      failures++;
      $display("FAIL busy_any_clear got=%b/%b busy1=%b exp 0", busy_any_a, busy_any_b, busy1_a);
    end
  endtask

  task automatic test_reset_mid();
    wb_we = 1; wb_wa = 3; wb_wd = 32'hFF;
    iss_valid = 1; iss_rd = 1;
    tick();
    idle(); iss_valid = 1; iss_rd = 2;
    tick();
    idle();
    tick();
    ra1 = 3; ra2 = 1;
    #1;
    checks++;
    if (busy_any_a !== 1'b1 || rd1_a !== 32'hFF || busy2_a !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset any=%b rd=%h busy=%b exp 1 ff 1", busy_any_a, rd1_a, busy2_a);
    end
    areset = 1'b0;
    #1;
    checks++;
    if (rd1_a !== 32'h0 || rd1_b !== 32'h0 || busy_any_a !== 1'b0 || busy_any_b !== 1'b0) begin
      failures++;
      $display("FAIL async_reset rd=%h/%h any=%b/%b exp 0", rd1_a, rd1_b, busy_any_a, busy_any_b);
    end
    checks++;
    if (busy2_a !== 1'b0 || busy2_b !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_busy got=%b/%b exp=0", busy2_a, busy2_b);
    end
    wb_we = 1; wb_wa = 3; wb_wd = 32'hABCD; iss_valid = 1; iss_rd = 3;
    #1;
    checks++;
    if (rd1_a !== 32'h0) begin
      failures++;
      $display("FAIL reset_no_fwd got=%h exp=0", rd1_a);
    end
    tick();
    idle();
    #2 areset = 1'b1;
    tick();
    checks++;
    if (rd1_a !== 32'h0 || rd1_b !== 32'h0 || busy1_a !== 1'b0 || busy1_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_ignored rd=%h/%h busy=%b/%b exp 0", rd1_a, rd1_b, busy1_a, busy1_b);
    end
  endtask

  initial begin
    idle(); ra1 = 0; ra2 = 0; areset = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
